full_connect_2: RTL and testbench

Second fully connected layer of the handwritten-digit DNN accelerator. It computes 10 output neurons from a 128-element int8 hidden-activation vector using 10 weight rows of 128 int8 each. It fetches one weight row per neuron from weight ROM and the hidden vector from activation RAM. Each dot product is delegated to the shared external MultAdder, and the result is requantized to int8. The 10 output bytes go to RAM as one 80-bit word, with `done` and a sticky `overflow` flag.

---
 rtl/full_connect_2.sv | 176 +++++++++++++++++
 tb/tb_full_connect_2.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/full_connect_2.sv
// full_connect_2: second fully connected layer (128 -> 10) of the digit DNN.
// Fetches one weight row per neuron, hands the dot product to the external
// MultAdder, requantizes the sum to int8 and packs the 10 logits into one word.
//
// Ports:
//   clk                      clock, rising edge
//   iRst_n                   asynchronous reset, active-high
//   ena                      run enable; rising ena in IDLE starts a pass
//   data_from_rom   [1023:0] weight row, byte k at [8k+7:8k]
//   data_from_ram   [1023:0] hidden activation vector, same packing
//   data_from_MultAdder [14:0] signed dot product of opr1/opr2
//   overflow_from_MultAdder  MultAdder overflow for the current operands
//   overflow                 sticky overflow/saturation flag for the pass
//   done                     all 10 bytes valid, held while ena stays high
//   addr_to_rom     [31:0]   registered weight-row address
//   addr_to_ram     [31:0]   registered activation-vector address
//   opr1_to_MultAdder [1023:0] combinational copy of data_from_rom
//   opr2_to_MultAdder [1023:0] combinational copy of data_from_ram
//   data_to_ram     [79:0]   neuron i result at [8i+7:8i]

module full_connect_2 #(
  parameter int unsigned ROM_BASE = 0,
  parameter int unsigned RAM_ADDR = 0,
  parameter int unsigned SHIFT    = 7
) (
  input  logic          clk,
  input  logic          iRst_n,
  input  logic          ena,
  input  logic [1023:0] data_from_rom,
  input  logic [1023:0] data_from_ram,
  input  logic [14:0]   data_from_MultAdder,
  input  logic          overflow_from_MultAdder,
  output logic          overflow,
  output logic          done,
  output logic [31:0]   addr_to_rom,
  output logic [31:0]   addr_to_ram,
  output logic [1023:0] opr1_to_MultAdder,
  output logic [1023:0] opr2_to_MultAdder,
  output logic [79:0]   data_to_ram
);

  localparam int unsigned SUM_W     = 15;
  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned N_NEURONS = 10;
  localparam int unsigned OUT_W     = N_NEURONS * BYTE_W;
  localparam int unsigned ADDR_W    = 32;
  localparam int unsigned IDX_W     = 4;

  localparam logic [IDX_W-1:0]        LAST_IDX = IDX_W'(N_NEURONS - 1);
  localparam logic [ADDR_W-1:0]       ROM_A    = ADDR_W'(ROM_BASE);
  localparam logic [ADDR_W-1:0]       RAM_A    = ADDR_W'(RAM_ADDR);
  localparam logic signed [SUM_W-1:0] Q_MAX    = 15'sd127;
  localparam logic signed [SUM_W-1:0] Q_MIN    = -15'sd128;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    WAIT,
    CAPT,
    DONE
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               ena_q;
  logic [ADDR_W-1:0]  addr_d;
  logic               done_d;
  logic               ovf_d;
  logic [OUT_W-1:0]   data_d;

  logic signed [SUM_W-1:0] sum_s;
  logic signed [SUM_W-1:0] q;
  logic                    sat_hi;
  logic                    sat_lo;
  logic                    saturated;
  logic [BYTE_W-1:0]       q_byte;

  // Operands go straight through so the MultAdder sees memory data with no latency.
  assign opr1_to_MultAdder = data_from_rom;
  assign opr2_to_MultAdder = data_from_ram;

  // Requantize: arithmetic shift, then clamp to int8.
  assign sum_s     = signed'(data_from_MultAdder);
  assign q         = sum_s >>> SHIFT;
  assign sat_hi    = (q > Q_MAX);
  assign sat_lo    = (q < Q_MIN);
  assign saturated = sat_hi | sat_lo;
  assign q_byte    = sat_hi ? 8'h7F : (sat_lo ? 8'h80 : q[BYTE_W-1:0]);

  // State and output registers.
  always_ff @(posedge clk or posedge iRst_n) begin
    if (iRst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      ena_q       <= 1'b0;
      addr_to_rom <= ROM_A;
      addr_to_ram <= RAM_A;
      done        <= 1'b0;
      overflow    <= 1'b0;
      data_to_ram <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      ena_q       <= ena;
      addr_to_rom <= addr_d;
      addr_to_ram <= RAM_A;
      done        <= done_d;
      overflow    <= ovf_d;
      data_to_ram <= data_d;
    end
  end

  // Next-state and next-output logic. Dropping ena outside IDLE abandons the
  // pass before any capture in that cycle, so already-written bytes survive.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    addr_d  = addr_to_rom;
    done_d  = done;
    ovf_d   = overflow;
    data_d  = data_to_ram;

    case (state_q)
      IDLE: begin
        // Start only on a rising ena so a held-high ena cannot relaunch.
        if (ena && !ena_q) begin
          state_d = ADDR;
          idx_d   = '0;
          addr_d  = ROM_A;
          ovf_d   = 1'b0;
        end
      end

      ADDR: begin
        state_d = ena ? WAIT : IDLE;
      end

      WAIT: begin
        state_d = ena ? CAPT : IDLE;
      end

      CAPT: begin
        if (!ena) begin
          state_d = IDLE;
        end else begin
          for (int k = 0; k < int'(N_NEURONS); k++) begin
            if (idx_q == IDX_W'(k)) begin
              data_d[k*BYTE_W +: BYTE_W] = q_byte;
            end
          end
          ovf_d = overflow | overflow_from_MultAdder | saturated;
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            addr_d  = ROM_A + ADDR_W'(idx_q) + ADDR_W'(1);
            state_d = ADDR;
          end
        end
      end

      DONE: begin
        if (!ena) begin
          state_d = IDLE;
          done_d  = 1'b0;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_full_connect_2.sv
// tb_full_connect_2: directed self-checking bench for full_connect_2.
// Two instances share all inputs: u_dut uses SHIFT=7, u_dut3 uses SHIFT=3.

module tb_full_connect_2;

  localparam int unsigned ROM_B = 16;
  localparam int unsigned RAM_B = 5;

  logic          clk;
  logic          rst;
  logic          ena;
  logic [1023:0] rom_data;
  logic [1023:0] ram_data;
  logic [14:0]   sum;
  logic          ovf_in;

  logic          overflow, overflow3;
  logic          done, done3;
  logic [31:0]   addr_rom, addr_rom3;
  logic [31:0]   addr_ram, addr_ram3;
  logic [1023:0] opr1, opr1_3;
  logic [1023:0] opr2, opr2_3;
  logic [79:0]   data_out, data_out3;

  int checks;
  int failures;

  full_connect_2 #(.ROM_BASE(ROM_B), .RAM_ADDR(RAM_B), .SHIFT(7)) u_dut (
    .clk                     (clk),
    .iRst_n                  (rst),
    .ena                     (ena),
    .data_from_rom           (rom_data),
    .data_from_ram           (ram_data),
    .data_from_MultAdder     (sum),
    .overflow_from_MultAdder (ovf_in),
    .overflow                (overflow),
    .done                    (done),
    .addr_to_rom             (addr_rom),
    .addr_to_ram             (addr_ram),
    .opr1_to_MultAdder       (opr1),
    .opr2_to_MultAdder       (opr2),
    .data_to_ram             (data_out)
  );

  full_connect_2 #(.ROM_BASE(ROM_B), .RAM_ADDR(RAM_B), .SHIFT(3)) u_dut3 (
    .clk                     (clk),
    .iRst_n                  (rst),
    .ena                     (ena),
    .data_from_rom           (rom_data),
    .data_from_ram           (ram_data),
    .data_from_MultAdder     (sum),
    .overflow_from_MultAdder (ovf_in),
    .overflow                (overflow3),
    .done                    (done3),
    .addr_to_rom             (addr_rom3),
    .addr_to_ram             (addr_ram3),
    .opr1_to_MultAdder       (opr1_3),
    .opr2_to_MultAdder       (opr2_3),
    .data_to_ram             (data_out3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    ena      = 1'b0;
    rom_data = '0;
    ram_data = '0;
    sum      = '0;
    ovf_in   = 1'b0;
    #12;
    rst = 1'b0;
    for (int c = 0; c < 3; c++) step();
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_ovf: got %b want 0", overflow); end
    checks++; if (data_out !== 80'h0) begin failures++; $display("FAIL reset_data: got %h want 0", data_out); end
    checks++; if (addr_rom !== 32'd16) begin failures++; $display("FAIL reset_addr_rom: got %h want 10", addr_rom); end
    checks++; if (addr_ram !== 32'd5) begin failures++; $display("FAIL reset_addr_ram: got %h want 5", addr_ram); end
    checks++; if (done3 !== 1'b0 || data_out3 !== 80'h0) begin failures++; $display("FAIL reset_dut3: got done=%b data=%h want 0/0", done3, data_out3); end
  endtask

  // 323 >>> 7 = 2 and 323 >>> 3 = 40 (0x28) on every neuron.
  task automatic test_basic();
    logic [31:0] exp_addr;
    logic        exp_done;
    int          k;
    rom_data = {128{8'h01}};
    ram_data = {128{8'h02}};
    sum      = 15'h0143;
    ovf_in   = 1'b0;
    ena      = 1'b1;
    for (int e = 1; e <= 31; e++) begin
      step();
      k        = (e - 1) / 3;
      if (k > 9) k = 9;
      exp_addr = 32'(ROM_B + k);
      exp_done = (e == 31);
      checks++; if (addr_rom !== exp_addr) begin failures++; $display("FAIL basic_addr_e%0d: got %h want %h", e, addr_rom, exp_addr); end
      checks++; if (done !== exp_done) begin failures++; $display("FAIL basic_done_e%0d: got %b want %b", e, done, exp_done); end
    end
    checks++; if (data_out !== {10{8'h02}}) begin failures++; $display("FAIL basic_data: got %h want %h", data_out, {10{8'h02}}); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL basic_ovf: got %b want 0", overflow); end
    checks++; if (data_out3 !== {10{8'h28}}) begin failures++; $display("FAIL basic_data3: got %h want %h", data_out3, {10{8'h28}}); end
    checks++; if (opr1 !== {128{8'h01}}) begin failures++; $display("FAIL basic_opr1: got %h", opr1[31:0]); end
    checks++; if (opr2 !== {128{8'h02}}) begin failures++; $display("FAIL basic_opr2: got %h", opr2[31:0]); end
    checks++; if (addr_ram !== 32'd5) begin failures++; $display("FAIL basic_addr_ram: got %h want 5", addr_ram); end
    // done holds while ena stays high
    step();
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL basic_done_hold: got %b want 1", done); end
    ena = 1'b0;
    step();
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL basic_done_clear: got %b want 0", done); end
  endtask

  // -16384 >>> 7 = -128 fits; -16384 >>> 3 = -2048 clamps to -128 and flags.
  task automatic test_saturate();
    sum = 15'h4000;
    ena = 1'b1;
    for (int e = 1; e <= 31; e++) step();
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL sat_done: got %b want 1", done); end
    checks++; if (data_out !== {10{8'h80}}) begin failures++; $display("FAIL sat_data7: got %h want %h", data_out, {10{8'h80}}); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL sat_ovf7: got %b want 0", overflow); end
    checks++; if (data_out3 !== {10{8'h80}}) begin failures++; $display("FAIL sat_data3: got %h want %h", data_out3, {10{8'h80}}); end
    checks++; if (overflow3 !== 1'b1) begin failures++; $display("FAIL sat_ovf3: got %b want 1", overflow3); end
    ena = 1'b0;
    step();
  endtask

  // MultAdder overflow only during neuron 4's CAPT cycle (edges 15..16).
  task automatic test_overflow_flag();
    sum = 15'h0143;
    ena = 1'b1;
    for (int e = 1; e <= 31; e++) begin
      step();
      if (e == 1) begin
        checks++; if (overflow3 !== 1'b0) begin failures++; $display("FAIL ovf_start_clear3: got %b want 0", overflow3); end
      end
      if (e == 15) begin
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_before_n4: got %b want 0", overflow); end
        ovf_in = 1'b1;
      end
      if (e == 16) begin
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_at_n4: got %b want 1", overflow); end
        ovf_in = 1'b0;
      end
    end
    checks++; if (done !== 1'b1 || overflow !== 1'b1) begin failures++; $display("FAIL ovf_at_done: got done=%b ovf=%b want 1/1", done, overflow); end
    ena = 1'b0;
    step();
  endtask

  // A clean pass must clear the sticky flag left by the previous pass.
  task automatic test_clear();
    ena = 1'b1;
    for (int e = 1; e <= 31; e++) begin
      step();
      if (e == 1) begin
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL clear_start: got %b want 0", overflow); end
      end
    end
    checks++; if (done !== 1'b1 || overflow !== 1'b0) begin failures++; $display("FAIL clear_done: got done=%b ovf=%b want 1/0", done, overflow); end
    ena = 1'b0;
    step();
  endtask

  // 640 >>> 7 = 5, 640 >>> 3 = 80. ena falls before edge 10, so neuron 2's
  // capture is abandoned; only bytes 0-1 change.
  task automatic test_abort();
    logic [79:0] exp7;
    logic [79:0] exp3;
    exp7       = {10{8'h02}};
    exp7[15:0] = 16'h0505;
    exp3       = {10{8'h28}};
    exp3[15:0] = 16'h5050;
    sum = 15'h0280;
    ena = 1'b1;
    for (int e = 1; e <= 9; e++) step();
    ena = 1'b0;
    for (int e = 10; e <= 16; e++) begin
      step();
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL abort_done_e%0d: got %b want 0", e, done); end
    end
    checks++; if (data_out !== exp7) begin failures++; $display("FAIL abort_data7: got %h want %h", data_out, exp7); end
    checks++; if (data_out3 !== exp3) begin failures++; $display("FAIL abort_data3: got %h want %h", data_out3, exp3); end
  endtask

  // Reset raised between edges must clear outputs without waiting for a clock.
  task automatic test_async_reset();
    sum    = 15'h0143;
    ovf_in = 1'b1;
    ena    = 1'b1;
    for (int e = 1; e <= 8; e++) step();
    checks++; if (overflow !== 1'b1 || addr_rom !== 32'd18) begin failures++; $display("FAIL arst_pre: got ovf=%b addr=%h want 1/12", overflow, addr_rom); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (done !== 1'b0 || overflow !== 1'b0) begin failures++; $display("FAIL arst_flags: got done=%b ovf=%b want 0/0", done, overflow); end
    checks++; if (data_out !== 80'h0) begin failures++; $display("FAIL arst_data: got %h want 0", data_out); end
    checks++; if (addr_rom !== 32'd16 || addr_ram !== 32'd5) begin failures++; $display("FAIL arst_addr: got %h/%h want 10/5", addr_rom, addr_ram); end
    ena    = 1'b0;
    ovf_in = 1'b0;
    #1;
    rst = 1'b0;
    step();
    checks++; if (done !== 1'b0 || data_out !== 80'h0) begin failures++; $display("FAIL arst_after: got done=%b data=%h want 0/0", done, data_out); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_basic();
    test_saturate();
    test_overflow_flag();
    test_clear();
    test_abort();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
